// File: rtl/fa_response_checker.sv
// Response checker for the full-adder block: compares observed {s,d} against the
// golden full-adder function and keeps pass/error counts, coverage and a verdict FSM.
module fa_response_checker #(
    parameter int CNT_W = 8
) (
    input  logic             i_clk,
    input  logic             i_rst,
    input  logic             i_clear,
    input  logic             i_in_valid,
    input  logic             i_a,
    input  logic             i_b,
    input  logic             i_c,
    input  logic             i_s,
    input  logic             i_d,
    output logic [CNT_W-1:0] o_pass_cnt,
    output logic [CNT_W-1:0] o_err_cnt,
    output logic [7:0]       o_cov_mask,
    output logic             o_all_covered,
    output logic             o_err_flag,
    output logic [4:0]       o_first_err_vec,
    output logic [1:0]       o_state
);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2,
        ST_FAIL = 2'd3
    } state_t;

    localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);
    localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};

    // Golden full adder, returned as {sum, carry}
    function automatic logic [1:0] fa_golden(input logic a, input logic b, input logic c);
        return {a ^ b ^ c, (a & b) | (a & c) | (b & c)};
    endfunction

    logic [CNT_W-1:0] r_pass_cnt;
    logic [CNT_W-1:0] r_err_cnt;
    logic [7:0]       r_cov_mask;
    logic             r_all_covered;
    logic             r_err_flag;
    logic [4:0]       r_first_err_vec;
    state_t           r_state;

    logic [2:0] w_idx;
    logic [1:0] w_exp;
    logic       w_match;
    logic [7:0] w_cov_next;

    assign w_idx      = {i_a, i_b, i_c};
    assign w_exp      = fa_golden(i_a, i_b, i_c);
    assign w_match    = ({i_s, i_d} == w_exp);
    assign w_cov_next = r_cov_mask | (8'd1 << w_idx);

    // Sample accounting and verdict FSM; clear discards any coincident sample
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_pass_cnt      <= '0;
            r_err_cnt       <= '0;
            r_cov_mask      <= 8'h00;
            r_all_covered   <= 1'b0;
            r_err_flag      <= 1'b0;
            r_first_err_vec <= 5'b00000;
            r_state         <= ST_IDLE;
        end else if (i_clear) begin
            r_pass_cnt      <= '0;
            r_err_cnt       <= '0;
            r_cov_mask      <= 8'h00;
            r_all_covered   <= 1'b0;
            r_err_flag      <= 1'b0;
            r_first_err_vec <= 5'b00000;
            r_state         <= ST_IDLE;
        end else if (i_in_valid) begin
            r_cov_mask    <= w_cov_next;
            r_all_covered <= (w_cov_next == 8'hFF);
            if (w_match) begin
                if (r_pass_cnt != CNT_MAX) begin
                    r_pass_cnt <= r_pass_cnt + CNT_ONE;
                end else begin
                    r_pass_cnt <= r_pass_cnt;
                end
            end else begin
                if (r_err_cnt != CNT_MAX) begin
                    r_err_cnt <= r_err_cnt + CNT_ONE;
                end else begin
                    r_err_cnt <= r_err_cnt;
                end
                r_err_flag <= 1'b1;
                // Only the first mismatch since reset/clear is recorded
                if (!r_err_flag) begin
                    r_first_err_vec <= {i_a, i_b, i_c, i_s, i_d};
                end else begin
                    r_first_err_vec <= r_first_err_vec;
                end
            end
            case (r_state)
                ST_IDLE: r_state <= w_match ? ST_RUN : ST_FAIL;
                ST_RUN: begin
                    if (!w_match) begin
                        r_state <= ST_FAIL;
                    end else if (w_cov_next == 8'hFF) begin
                        r_state <= ST_DONE;
                    end else begin
                        r_state <= ST_RUN;
                    end
                end
                ST_DONE: r_state <= w_match ? ST_DONE : ST_FAIL;
                ST_FAIL: r_state <= ST_FAIL;
                default: r_state <= ST_FAIL;
            endcase
        end else begin
            r_state <= r_state;
        end
    end

    assign o_pass_cnt      = r_pass_cnt;
    assign o_err_cnt       = r_err_cnt;
    assign o_cov_mask      = r_cov_mask;
    assign o_all_covered   = r_all_covered;
    assign o_err_flag      = r_err_flag;
    assign o_first_err_vec = r_first_err_vec;
    assign o_state         = r_state;

endmodule

// File: tb/tb_fa_response_checker.sv
// Directed bench for fa_response_checker: one task per scenario with hand-computed expectations.
module tb_fa_response_checker;

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic clear = 1'b0;
    logic in_valid = 1'b0;
    logic a = 1'b0, b = 1'b0, c = 1'b0, s = 1'b0, d = 1'b0;

    logic [7:0] pass_cnt, err_cnt, cov_mask;
    logic       all_covered, err_flag;
    logic [4:0] first_err_vec;
    logic [1:0] state;

    logic [2:0] pass3, err3;
    logic [7:0] cov3;
    logic       allc3, flag3;
    logic [4:0] fev3;
    logic [1:0] state3;

    int checks = 0;
    int errors = 0;

    // Correct {s,d} for input index 0..7, two bits per entry
    logic [15:0] gold_tbl = 16'b1101_0110_0110_1000;

    always #5 clk = ~clk;

    fa_response_checker #(.CNT_W(8)) dut (
        .i_clk(clk), .i_rst(rst), .i_clear(clear), .i_in_valid(in_valid),
        .i_a(a), .i_b(b), .i_c(c), .i_s(s), .i_d(d),
        .o_pass_cnt(pass_cnt), .o_err_cnt(err_cnt), .o_cov_mask(cov_mask),
        .o_all_covered(all_covered), .o_err_flag(err_flag),
        .o_first_err_vec(first_err_vec), .o_state(state)
    );

    fa_response_checker #(.CNT_W(3)) dut3 (
        .i_clk(clk), .i_rst(rst), .i_clear(clear), .i_in_valid(in_valid),
        .i_a(a), .i_b(b), .i_c(c), .i_s(s), .i_d(d),
        .o_pass_cnt(pass3), .o_err_cnt(err3), .o_cov_mask(cov3),
        .o_all_covered(allc3), .o_err_flag(flag3),
        .o_first_err_vec(fev3), .o_state(state3)
    );

    task automatic apply(input logic [2:0] v, input logic [1:0] o);
        @(negedge clk);
        {a, b, c} = v;
        {s, d} = o;
        in_valid = 1'b1;
        @(posedge clk);
        #1;
    endtask

    task automatic idle(input int n);
        @(negedge clk);
        in_valid = 1'b0;
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic do_clear();
        @(negedge clk);
        in_valid = 1'b0;
        clear = 1'b1;
        @(negedge clk);
        clear = 1'b0;
    endtask

    task automatic test_reset();
        @(negedge clk);
        rst = 1'b0;
        apply(3'b000, 2'b00);
        checks++;
        if (pass_cnt !== 8'd1 || state !== 2'd1) begin
            $display("FAIL reset_pre: pass=%0d state=%0d, want pass=1 state=1", pass_cnt, state);
            errors++;
        end
        in_valid = 1'b0;
        #2 rst = 1'b1;
        #1;
        checks++;
        if ({pass_cnt, err_cnt, cov_mask, all_covered, err_flag, first_err_vec, state} !== 33'd0) begin
            $display("FAIL reset_async: pass=%0d err=%0d cov=%h allc=%b flag=%b fev=%b state=%0d, want all zero",
                     pass_cnt, err_cnt, cov_mask, all_covered, err_flag, first_err_vec, state);
            errors++;
        end
        @(negedge clk);
        rst = 1'b0;
        idle(5);
        checks++;
        if ({pass_cnt, err_cnt, cov_mask, all_covered, err_flag, first_err_vec, state} !== 33'd0) begin
            $display("FAIL reset_idle: pass=%0d err=%0d cov=%h state=%0d, want all zero",
                     pass_cnt, err_cnt, cov_mask, state);
            errors++;
        end
    endtask

    task automatic run_exhaustive(input logic check_mid);
        for (int i = 0; i < 8; i++) begin
            apply(3'(i), gold_tbl[2*i +: 2]);
            if (check_mid && i == 6) begin
                checks++;
                if (state !== 2'd1 || pass_cnt !== 8'd7 || all_covered !== 1'b0) begin
                    $display("FAIL exh_7th: state=%0d pass=%0d allc=%b, want 1 7 0", state, pass_cnt, all_covered);
                    errors++;
                end
            end
        end
    endtask

    task automatic test_exhaustive_pass();
        do_clear();
        run_exhaustive(1'b1);
        idle(1);
        checks++;
        if (pass_cnt !== 8'd8) begin
            $display("FAIL exh_pass: got %0d want 8", pass_cnt); errors++;
        end
        checks++;
        if (err_cnt !== 8'd0 || err_flag !== 1'b0) begin
            $display("FAIL exh_err: err=%0d flag=%b want 0 0", err_cnt, err_flag); errors++;
        end
        checks++;
        if (cov_mask !== 8'hFF || all_covered !== 1'b1) begin
            $display("FAIL exh_cov: cov=%h allc=%b want ff 1", cov_mask, all_covered); errors++;
        end
        checks++;
        if (state !== 2'd2) begin
            $display("FAIL exh_state: got %0d want 2", state); errors++;
        end
    endtask

    task automatic test_error_capture();
        do_clear();
        apply(3'b101, 2'b11);
        checks++;
        if (err_cnt !== 8'd1 || err_flag !== 1'b1 || first_err_vec !== 5'b10111 || state !== 2'd3) begin
            $display("FAIL err_first: err=%0d flag=%b fev=%b state=%0d, want 1 1 10111 3",
                     err_cnt, err_flag, first_err_vec, state);
            errors++;
        end
        checks++;
        if (cov_mask !== 8'h20 || pass_cnt !== 8'd0) begin
            $display("FAIL err_first_cov: cov=%h pass=%0d, want 20 0", cov_mask, pass_cnt); errors++;
        end
        apply(3'b111, 2'b01);
        checks++;
        if (err_cnt !== 8'd2 || first_err_vec !== 5'b10111 || cov_mask !== 8'hA0 || state !== 2'd3) begin
            $display("FAIL err_second: err=%0d fev=%b cov=%h state=%0d, want 2 10111 a0 3",
                     err_cnt, first_err_vec, cov_mask, state);
            errors++;
        end
        apply(3'b000, 2'b00);
        checks++;
        if (state !== 2'd3 || pass_cnt !== 8'd1) begin
            $display("FAIL err_absorb: state=%0d pass=%0d, want 3 1", state, pass_cnt); errors++;
        end
        idle(1);
    endtask

    task automatic test_clear_priority();
        @(negedge clk);
        {a, b, c} = 3'b101;
        {s, d} = 2'b11;
        in_valid = 1'b1;
        clear = 1'b1;
        @(posedge clk);
        #1;
        checks++;
        if ({pass_cnt, err_cnt, cov_mask, all_covered, err_flag, first_err_vec, state} !== 33'd0) begin
            $display("FAIL clear_prio: pass=%0d err=%0d cov=%h flag=%b fev=%b state=%0d, want all zero",
                     pass_cnt, err_cnt, cov_mask, err_flag, first_err_vec, state);
            errors++;
        end
        @(negedge clk);
        clear = 1'b0;
        in_valid = 1'b0;
    endtask

    task automatic test_saturation();
        do_clear();
        for (int i = 0; i < 7; i++) apply(3'(i), gold_tbl[2*i +: 2]);
        checks++;
        if (pass3 !== 3'd7) begin
            $display("FAIL sat_reach: got %0d want 7", pass3); errors++;
        end
        for (int i = 0; i < 3; i++) apply(3'(i), gold_tbl[2*i +: 2]);
        idle(1);
        checks++;
        if (pass3 !== 3'd7 || err3 !== 3'd0) begin
            $display("FAIL sat_hold: pass=%0d err=%0d want 7 0", pass3, err3); errors++;
        end
        checks++;
        if (pass_cnt !== 8'd10) begin
            $display("FAIL sat_wide: got %0d want 10", pass_cnt); errors++;
        end
    endtask

    task automatic test_late_failure();
        do_clear();
        run_exhaustive(1'b0);
        apply(3'b000, 2'b10);
        idle(1);
        checks++;
        if (state !== 2'd3 || all_covered !== 1'b1) begin
            $display("FAIL late_state: state=%0d allc=%b want 3 1", state, all_covered); errors++;
        end
        checks++;
        if (pass_cnt !== 8'd8 || err_cnt !== 8'd1 || first_err_vec !== 5'b00010) begin
            $display("FAIL late_cnt: pass=%0d err=%0d fev=%b want 8 1 00010", pass_cnt, err_cnt, first_err_vec);
            errors++;
        end
    endtask

    initial begin
        test_reset();
        test_exhaustive_pass();
        test_error_capture();
        test_clear_priority();
        test_saturation();
        test_late_failure();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/fa_response_checker.md
# fa_response_checker

Synthesizable response checker for the full-adder block. It takes the applied input vector `{a,b,c}` and the DUT's observed outputs `{s,d}` on a qualified cycle, compares them against the golden full-adder function, and accumulates pass/error counts and input-space coverage. It also records the first failing vector. It sits on the output side of the full-adder stimulus path, so benches and on-chip self-test can report a verdict without waveform inspection.

## Interface
- `CNT_W`, default 8: width of the pass and error counters; both saturate.
- `clk`  input  1  rising-edge clock.
- `rst`  input  1  asynchronous, active-high reset.
- `clear`  input  1  synchronous clear of all state; same effect as reset, applied at the clock edge.
- `in_valid`  input  1  sample qualifier; `a,b,c,s,d` are checked only on edges where it is high.
- `a`, `b`, `c`  input  1 each  vector applied to the full adder (`c` = carry-in).
- `s`, `d`  input  1 each  observed DUT sum and carry-out.
- `pass_cnt`  output  `CNT_W`  number of matching samples.
- `err_cnt`  output  `CNT_W`  number of mismatching samples.
- `cov_mask`  output  8  bit `{a,b,c}` is set once that input combination has been sampled.
- `all_covered`  output  1  high when `cov_mask == 8'hFF`.
- `err_flag`  output  1  sticky; high after any mismatch.
- `first_err_vec`  output  5  `{a,b,c,s,d}` of the first mismatching sample.
- `state`  output  2  0=IDLE, 1=RUN, 2=DONE, 3=FAIL.

## Operation
- Golden model: `exp_s = a^b^c`; `exp_d = (a&b)|(a&c)|(b&c)`.
- A sample matches when `s==exp_s && d==exp_d`.
- On a valid edge:
  - a match increments `pass_cnt`; a mismatch increments `err_cnt`.
  - `cov_mask[{a,b,c}]` is set whether or not the sample matches.
- Counters saturate at all-ones and never wrap.
- `first_err_vec` is captured only when `err_flag` is low before that edge. Later mismatches leave it unchanged.
- FSM:
  - IDLE → RUN on a valid match.
  - IDLE/RUN/DONE → FAIL on a valid mismatch. FAIL has priority over DONE.
  - RUN → DONE when the updated coverage (including this sample) is `8'hFF` and the sample matches.
  - DONE stays in DONE on further matches; counts keep accumulating.
  - FAIL is absorbing until `clear` or `rst`.
- `in_valid` low: no register changes.
- `clear` and `in_valid` high on the same edge: `clear` wins and the sample is discarded.
- Reset and clear values: `pass_cnt=0`, `err_cnt=0`, `cov_mask=0`, `all_covered=0`, `err_flag=0`, `first_err_vec=0`, `state=IDLE`.

## Timing
- All outputs are registered. The effect of a sample at edge N is visible immediately after edge N (one-cycle latency from input setup).
- `all_covered` and `state` update on the same edge as the sample that completes coverage.
- `rst` assertion forces reset values immediately, without a clock edge. Deassertion takes effect at the next rising edge. A mid-run reset discards all accumulated results.
- The block accepts back-to-back valid samples every cycle; there is no backpressure.
- Inputs must be stable around the rising edge where `in_valid` is high.

## Test plan
- **Reset:** assert `rst` asynchronously between edges → all outputs 0 and `state=0` immediately. Deassert, then idle 5 cycles with `in_valid=0` → no change.
- **Exhaustive pass:** apply vectors 000..111 with correct `s,d` on 8 consecutive valid cycles → after the 8th edge: `pass_cnt=8`, `err_cnt=0`, `cov_mask=8'hFF`, `all_covered=1`, `state=2`. After the 7th edge: `state=1`.
- **Error capture:** `a=1,b=0,c=1,s=1,d=1` (expected `s=0,d=1`) → `err_cnt=1`, `err_flag=1`, `first_err_vec=5'b10111`, `state=3`. A following mismatch `a=1,b=1,c=1,s=0,d=1` → `err_cnt=2`, `first_err_vec` still `5'b10111`, `cov_mask=8'hA0`.
- **Saturation:** with `CNT_W=3`, apply 10 correct samples → `pass_cnt=3'd7`, and it holds at 7.
- **Clear priority:** `clear=1` together with `in_valid=1` carrying a mismatching vector → all outputs return to reset values, `err_flag=0`, and the sample is not counted.
- **Late failure:** reach DONE via the exhaustive pass, then one mismatch → `state=3`, `all_covered` stays 1, `pass_cnt` stays 8, `err_cnt=1`.
